// File: rtl/pipeline_acc_mc_if.sv
// Operand/result bundle for the multi-lane pipelined accumulator.
// The master drives the control and operand stream, and the slave returns the results.
interface pipeline_acc_mc_if #(
    parameter int C_CH  = 4,
    parameter int C_CNT = 8,
    parameter int C_IN1 = 12,
    parameter int C_OUT = 20
);
    logic [C_CNT-1:0]       I_cnt_boundary;
    logic                   I_op_en;
    logic                   I_op_rdy;
    logic [C_CH*C_IN1-1:0]  I_operand;
    logic                   O_result_first_flag;
    logic                   O_result_rdy_pre;
    logic                   O_result_vld;
    logic [C_CH*C_OUT-1:0]  O_result;
    logic [C_CH-1:0]        O_result_sat;

    modport master (
        output I_cnt_boundary, I_op_en, I_op_rdy, I_operand,
        input  O_result_first_flag, O_result_rdy_pre, O_result_vld, O_result, O_result_sat
    );

    modport slave (
        input  I_cnt_boundary, I_op_en, I_op_rdy, I_operand,
        output O_result_first_flag, O_result_rdy_pre, O_result_vld, O_result, O_result_sat
    );
endinterface

// File: rtl/pipeline_acc_mc.sv
// Multi-lane group accumulator. Each result appears at a fixed latency, and an early-ready strobe precedes it.
// Define PIPELINE_ACC_MC_SAT_EN for saturating lanes with sticky flags. By default the lanes wrap.
module pipeline_acc_mc #(
    parameter int C_CH  = 4,
    parameter int C_CNT = 8,
    parameter int C_IN1 = 12,
    parameter int C_OUT = 20,
    parameter int C_LAT = 6,
    parameter int C_PRE = 4
) (
    input  logic             I_clk,
    input  logic             I_rst,
    pipeline_acc_mc_if.slave bus
);
    localparam int C_DEPTH = C_LAT - 1;
`ifdef PIPELINE_ACC_MC_SAT_EN
    localparam int C_W = C_OUT + 1;
`else
    localparam int C_W = C_OUT;
`endif

    logic [C_CNT-1:0]        eff_bnd;
    logic [C_CNT-1:0]        cnt;
    logic                    op_en_d;
    logic                    first_pend;
    logic signed [C_OUT-1:0] acc     [C_CH];
    logic signed [C_OUT-1:0] acc_nxt [C_CH];
    logic signed [C_W-1:0]   base    [C_CH];
    logic signed [C_W-1:0]   op_ext  [C_CH];
    logic signed [C_W-1:0]   wide    [C_CH];
    logic [C_CH*C_OUT-1:0]   sum_flat;
    logic                    acc_en;
    logic                    last;
    logic                    group_first;

    logic                    vld_pipe   [C_DEPTH];
    logic                    first_pipe [C_DEPTH];
    logic [C_CH*C_OUT-1:0]   data_pipe  [C_DEPTH];
`ifdef PIPELINE_ACC_MC_SAT_EN
    logic [C_CH-1:0]         sat_acc;
    logic [C_CH-1:0]         sat_nxt;
    logic [C_CH-1:0]         sat_pipe   [C_DEPTH];
`endif

    assign acc_en      = bus.I_op_en & bus.I_op_rdy;
    assign last        = acc_en & (cnt == (eff_bnd - C_CNT'(1)));
    assign group_first = first_pend | (bus.I_op_en & ~op_en_d);

    // The next lane value is also the value that enters the delay line when a group completes.
    always_comb begin
        sum_flat = '0;
`ifdef PIPELINE_ACC_MC_SAT_EN
        sat_nxt = '0;
`endif
        for (int k = 0; k < C_CH; k++) begin
            op_ext[k]  = C_W'($signed(bus.I_operand[k*C_IN1 +: C_IN1]));
            base[k]    = (cnt == '0) ? '0 : C_W'(acc[k]);
            wide[k]    = base[k] + op_ext[k];
            acc_nxt[k] = wide[k][C_OUT-1:0];
`ifdef PIPELINE_ACC_MC_SAT_EN
            if (wide[k][C_OUT] != wide[k][C_OUT-1]) begin
                acc_nxt[k] = wide[k][C_OUT] ? {1'b1, {(C_OUT-1){1'b0}}} : {1'b0, {(C_OUT-1){1'b1}}};
                sat_nxt[k] = 1'b1;
            end else begin
                sat_nxt[k] = (cnt != '0) & sat_acc[k];
            end
`endif
            sum_flat[k*C_OUT +: C_OUT] = acc_nxt[k];
        end
    end

    // Dropping the enable discards any partial group and re-latches the group length.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            eff_bnd    <= C_CNT'(1);
            cnt        <= '0;
            op_en_d    <= 1'b0;
            first_pend <= 1'b0;
            for (int k = 0; k < C_CH; k++) acc[k] <= '0;
`ifdef PIPELINE_ACC_MC_SAT_EN
            sat_acc    <= '0;
`endif
        end else begin
            op_en_d <= bus.I_op_en;
            if (!bus.I_op_en) begin
                eff_bnd    <= (bus.I_cnt_boundary == '0) ? C_CNT'(1) : bus.I_cnt_boundary;
                cnt        <= '0;
                first_pend <= 1'b0;
                for (int k = 0; k < C_CH; k++) acc[k] <= '0;
`ifdef PIPELINE_ACC_MC_SAT_EN
                sat_acc    <= '0;
`endif
            end else begin
                if (!op_en_d) first_pend <= 1'b1;
                if (acc_en) begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    for (int k = 0; k < C_CH; k++) acc[k] <= acc_nxt[k];
`ifdef PIPELINE_ACC_MC_SAT_EN
                    sat_acc <= sat_nxt;
`endif
                    if (last) first_pend <= 1'b0;
                end
            end
        end
    end

    // Fixed-latency delay line. Entry j holds the groups that completed j+1 clocks earlier.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            for (int j = 0; j < C_DEPTH; j++) begin
                vld_pipe[j]   <= 1'b0;
                first_pipe[j] <= 1'b0;
                data_pipe[j]  <= '0;
`ifdef PIPELINE_ACC_MC_SAT_EN
                sat_pipe[j]   <= '0;
`endif
            end
            bus.O_result_vld        <= 1'b0;
            bus.O_result_first_flag <= 1'b0;
            bus.O_result            <= '0;
        end else begin
            vld_pipe[0]   <= last;
            first_pipe[0] <= last & group_first;
            data_pipe[0]  <= sum_flat;
`ifdef PIPELINE_ACC_MC_SAT_EN
            sat_pipe[0]   <= last ? sat_nxt : '0;
`endif
            for (int j = 1; j < C_DEPTH; j++) begin
                vld_pipe[j]   <= vld_pipe[j-1];
                first_pipe[j] <= first_pipe[j-1];
                data_pipe[j]  <= data_pipe[j-1];
`ifdef PIPELINE_ACC_MC_SAT_EN
                sat_pipe[j]   <= sat_pipe[j-1];
`endif
            end
            bus.O_result_vld        <= vld_pipe[C_DEPTH-1];
            bus.O_result_first_flag <= vld_pipe[C_DEPTH-1] & first_pipe[C_DEPTH-1];
            if (vld_pipe[C_DEPTH-1]) bus.O_result <= data_pipe[C_DEPTH-1];
        end
    end

`ifdef PIPELINE_ACC_MC_SAT_EN
    always_ff @(posedge I_clk) begin
        if (I_rst) bus.O_result_sat <= '0;
        else       bus.O_result_sat <= vld_pipe[C_DEPTH-1] ? sat_pipe[C_DEPTH-1] : '0;
    end
`else
    assign bus.O_result_sat = '0;
`endif

    assign bus.O_result_rdy_pre = vld_pipe[C_LAT-C_PRE-1];
endmodule

// File: tb/tb_pipeline_acc_mc.sv
// Directed bench for pipeline_acc_mc. It uses a 20-bit instance for the main checks and a 12-bit twin for overflow.
module tb_pipeline_acc_mc;
    localparam int C_CH = 4, C_CNT = 8, C_IN1 = 12, C_OUT = 20, C_LAT = 6, C_PRE = 4;
    localparam int C_OUT12 = 12;

    logic I_clk = 1'b0;
    logic I_rst;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    pipeline_acc_mc_if #(.C_CH(C_CH), .C_CNT(C_CNT), .C_IN1(C_IN1), .C_OUT(C_OUT))   bus();
    pipeline_acc_mc_if #(.C_CH(C_CH), .C_CNT(C_CNT), .C_IN1(C_IN1), .C_OUT(C_OUT12)) bus12();

    pipeline_acc_mc #(.C_CH(C_CH), .C_CNT(C_CNT), .C_IN1(C_IN1), .C_OUT(C_OUT),
                      .C_LAT(C_LAT), .C_PRE(C_PRE)) dut (.I_clk(I_clk), .I_rst(I_rst), .bus(bus));
    pipeline_acc_mc #(.C_CH(C_CH), .C_CNT(C_CNT), .C_IN1(C_IN1), .C_OUT(C_OUT12),
                      .C_LAT(C_LAT), .C_PRE(C_PRE)) dut12 (.I_clk(I_clk), .I_rst(I_rst), .bus(bus12));

    assign bus12.I_cnt_boundary = bus.I_cnt_boundary;
    assign bus12.I_op_en        = bus.I_op_en;
    assign bus12.I_op_rdy       = bus.I_op_rdy;
    assign bus12.I_operand      = bus.I_operand;

    always #5 I_clk = ~I_clk;
    always @(posedge I_clk) cyc <= cyc + 1;

    // Log of every result pulse and every early-ready pulse from the main instance.
    int                    pulse_cyc[$];
    logic [C_CH*C_OUT-1:0] pulse_res[$];
    logic                  pulse_first[$];
    logic [C_CH-1:0]       pulse_sat[$];
    int                    pre_cyc[$];

    always @(negedge I_clk) begin
        if (bus.O_result_vld) begin
            pulse_cyc.push_back(cyc);
            pulse_res.push_back(bus.O_result);
            pulse_first.push_back(bus.O_result_first_flag);
            pulse_sat.push_back(bus.O_result_sat);
        end
        if (bus.O_result_rdy_pre) pre_cyc.push_back(cyc);
    end

    function automatic logic [C_CH*C_IN1-1:0] pack_ops(input int a, input int b, input int c, input int d);
        return {C_IN1'(d), C_IN1'(c), C_IN1'(b), C_IN1'(a)};
    endfunction

    function automatic logic [C_CH*C_OUT-1:0] pack_res(input int a, input int b, input int c, input int d);
        return {C_OUT'(d), C_OUT'(c), C_OUT'(b), C_OUT'(a)};
    endfunction

    task automatic drive_cycle(input logic en, input logic rdy, input logic [C_CH*C_IN1-1:0] ops);
        @(posedge I_clk);
        #1;
        bus.I_op_en    = en;
        bus.I_op_rdy   = rdy;
        bus.I_operand  = ops;
    endtask

    task automatic start_group(input int bnd);
        drive_cycle(1'b0, 1'b0, '0);
        bus.I_cnt_boundary = C_CNT'(bnd);
    endtask

    task automatic drain();
        repeat (12) drive_cycle(1'b0, 1'b0, '0);
    endtask

    task automatic clear_log();
        pulse_cyc.delete();
        pulse_res.delete();
        pulse_first.delete();
        pulse_sat.delete();
        pre_cyc.delete();
    endtask

    task automatic test_reset();
        int t;
        I_rst = 1'b1;
        bus.I_op_en = 1'b0;
        bus.I_op_rdy = 1'b0;
        bus.I_operand = '0;
        bus.I_cnt_boundary = '0;
        repeat (3) @(posedge I_clk);
        #1;
        I_rst = 1'b0;
        checks++; if (bus.O_result_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld: got %b, expected 0", bus.O_result_vld); end
        checks++; if (bus.O_result_rdy_pre !== 1'b0) begin errors++; $display("[TB] FAIL reset_pre: got %b, expected 0", bus.O_result_rdy_pre); end
        checks++; if (bus.O_result_first_flag !== 1'b0) begin errors++; $display("[TB] FAIL reset_first: got %b, expected 0", bus.O_result_first_flag); end
        checks++; if (bus.O_result !== '0) begin errors++; $display("[TB] FAIL reset_result: got %h, expected 0", bus.O_result); end
        checks++; if (bus.O_result_sat !== '0) begin errors++; $display("[TB] FAIL reset_sat: got %b, expected 0", bus.O_result_sat); end
        checks++; if (bus12.O_result !== '0) begin errors++; $display("[TB] FAIL reset_result12: got %h, expected 0", bus12.O_result); end

        clear_log();
        start_group(3);
        drive_cycle(1'b1, 1'b1, pack_ops(1, 0, 0, 0));
        drive_cycle(1'b1, 1'b1, pack_ops(2, 0, 0, 0));
        drive_cycle(1'b1, 1'b1, pack_ops(3, 0, 0, 0));
        t = cyc;
        drain();
        checks++; if (pulse_cyc.size() != 1) begin errors++; $display("[TB] FAIL first_group_count: got %0d pulses, expected 1", pulse_cyc.size()); end
        if (pulse_cyc.size() > 0) begin
            checks++; if (pulse_cyc[0] != t + C_LAT) begin errors++; $display("[TB] FAIL first_group_latency: got cycle %0d, expected %0d", pulse_cyc[0], t + C_LAT); end
            checks++; if (pulse_res[0] !== pack_res(6, 0, 0, 0)) begin errors++; $display("[TB] FAIL first_group_sum: got %h, expected %h", pulse_res[0], pack_res(6, 0, 0, 0)); end
            checks++; if (pulse_first[0] !== 1'b1) begin errors++; $display("[TB] FAIL first_group_flag: got %b, expected 1", pulse_first[0]); end
            checks++; if (pulse_sat[0] !== '0) begin errors++; $display("[TB] FAIL first_group_sat: got %b, expected 0", pulse_sat[0]); end
        end
        checks++; if (pre_cyc.size() != 1) begin errors++; $display("[TB] FAIL first_group_pre_count: got %0d, expected 1", pre_cyc.size()); end
        if (pre_cyc.size() > 0) begin
            checks++; if (pre_cyc[0] != t + C_LAT - C_PRE) begin errors++; $display("[TB] FAIL first_group_pre_time: got cycle %0d, expected %0d", pre_cyc[0], t + C_LAT - C_PRE); end
        end
    endtask

    task automatic test_back_to_back();
        int t0;
        clear_log();
        start_group(1);
        drive_cycle(1'b1, 1'b1, pack_ops(10, 11, 12, 13));
        t0 = cyc;
        repeat (7) drive_cycle(1'b1, 1'b1, pack_ops(10, 11, 12, 13));
        drain();
        checks++; if (pulse_cyc.size() != 8) begin errors++; $display("[TB] FAIL b2b_count: got %0d pulses, expected 8", pulse_cyc.size()); end
        for (int i = 0; i < pulse_cyc.size() && i < 8; i++) begin
            checks++; if (pulse_cyc[i] != t0 + C_LAT + i) begin errors++; $display("[TB] FAIL b2b_time[%0d]: got cycle %0d, expected %0d", i, pulse_cyc[i], t0 + C_LAT + i); end
            checks++; if (pulse_res[i] !== pack_res(10, 11, 12, 13)) begin errors++; $display("[TB] FAIL b2b_sum[%0d]: got %h, expected %h", i, pulse_res[i], pack_res(10, 11, 12, 13)); end
            checks++; if (pulse_first[i] !== (i == 0)) begin errors++; $display("[TB] FAIL b2b_first[%0d]: got %b, expected %b", i, pulse_first[i], i == 0); end
        end
    endtask

    task automatic test_gaps();
        int vals[4] = '{5, -3, 7, -1};
        int t;
        clear_log();
        start_group(4);
        t = 0;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b1, pack_ops(vals[i], -5, 0, 0));
            t = cyc;
            if (i < 3) repeat (2) drive_cycle(1'b1, 1'b0, pack_ops(99, 99, 99, 99));
        end
        drain();
        checks++; if (pulse_cyc.size() != 1) begin errors++; $display("[TB] FAIL gaps_count: got %0d pulses, expected 1", pulse_cyc.size()); end
        if (pulse_cyc.size() > 0) begin
            checks++; if (pulse_cyc[0] != t + C_LAT) begin errors++; $display("[TB] FAIL gaps_latency: got cycle %0d, expected %0d", pulse_cyc[0], t + C_LAT); end
            checks++; if (pulse_res[0] !== pack_res(8, -20, 0, 0)) begin errors++; $display("[TB] FAIL gaps_sum: got %h, expected %h", pulse_res[0], pack_res(8, -20, 0, 0)); end
            checks++; if (pulse_first[0] !== 1'b1) begin errors++; $display("[TB] FAIL gaps_first: got %b, expected 1", pulse_first[0]); end
        end
        if (pre_cyc.size() > 0) begin
            checks++; if (pre_cyc[0] != t + C_LAT - C_PRE) begin errors++; $display("[TB] FAIL gaps_pre_time: got cycle %0d, expected %0d", pre_cyc[0], t + C_LAT - C_PRE); end
        end
    endtask

    task automatic test_partial_discard();
        int t;
        clear_log();
        start_group(5);
        repeat (3) drive_cycle(1'b1, 1'b1, pack_ops(9, 9, 9, 9));
        drive_cycle(1'b0, 1'b1, pack_ops(9, 9, 9, 9));
        start_group(2);
        drive_cycle(1'b1, 1'b1, pack_ops(4, -4, 0, 1));
        drive_cycle(1'b1, 1'b1, pack_ops(4, -4, 0, 1));
        t = cyc;
        drain();
        checks++; if (pulse_cyc.size() != 1) begin errors++; $display("[TB] FAIL discard_count: got %0d pulses, expected 1", pulse_cyc.size()); end
        if (pulse_cyc.size() > 0) begin
            checks++; if (pulse_cyc[0] != t + C_LAT) begin errors++; $display("[TB] FAIL discard_latency: got cycle %0d, expected %0d", pulse_cyc[0], t + C_LAT); end
            checks++; if (pulse_res[0] !== pack_res(8, -8, 0, 2)) begin errors++; $display("[TB] FAIL discard_sum: got %h, expected %h", pulse_res[0], pack_res(8, -8, 0, 2)); end
            checks++; if (pulse_first[0] !== 1'b1) begin errors++; $display("[TB] FAIL discard_first: got %b, expected 1", pulse_first[0]); end
        end
    endtask

    task automatic test_overflow();
        int t;
        logic [C_CH*C_OUT12-1:0] exp12;
        logic [C_CH-1:0]         exp_sat12;
`ifdef PIPELINE_ACC_MC_SAT_EN
        exp12     = {12'h000, 12'h000, 12'h800, 12'h7FF};
        exp_sat12 = 4'b0011;
`else
        exp12     = {12'h000, 12'h000, 12'h000, 12'hFFE};
        exp_sat12 = 4'b0000;
`endif
        clear_log();
        start_group(2);
        drive_cycle(1'b1, 1'b1, pack_ops(2047, -2048, 0, 0));
        drive_cycle(1'b1, 1'b1, pack_ops(2047, -2048, 0, 0));
        t = cyc;
        while (cyc < t + C_LAT) drive_cycle(1'b0, 1'b0, '0);
        checks++; if (bus12.O_result_vld !== 1'b1) begin errors++; $display("[TB] FAIL ovf12_vld: got %b, expected 1", bus12.O_result_vld); end
        checks++; if (bus12.O_result !== exp12) begin errors++; $display("[TB] FAIL ovf12_sum: got %h, expected %h", bus12.O_result, exp12); end
        checks++; if (bus12.O_result_sat !== exp_sat12) begin errors++; $display("[TB] FAIL ovf12_sat: got %b, expected %b", bus12.O_result_sat, exp_sat12); end
        drain();
        checks++; if (pulse_cyc.size() != 1) begin errors++; $display("[TB] FAIL ovf20_count: got %0d pulses, expected 1", pulse_cyc.size()); end
        if (pulse_cyc.size() > 0) begin
            checks++; if (pulse_res[0] !== pack_res(4094, -4096, 0, 0)) begin errors++; $display("[TB] FAIL ovf20_sum: got %h, expected %h", pulse_res[0], pack_res(4094, -4096, 0, 0)); end
            checks++; if (pulse_sat[0] !== '0) begin errors++; $display("[TB] FAIL ovf20_sat: got %b, expected 0", pulse_sat[0]); end
        end
    endtask

    task automatic test_reset_mid_group();
        int t;
        clear_log();
        start_group(3);
        drive_cycle(1'b1, 1'b1, pack_ops(1, 1, 1, 1));
        drive_cycle(1'b1, 1'b1, pack_ops(1, 1, 1, 1));
        I_rst = 1'b1;
        start_group(3);
        I_rst = 1'b0;
        drive_cycle(1'b1, 1'b1, pack_ops(1, 1, 1, 1));
        drive_cycle(1'b1, 1'b1, pack_ops(1, 1, 1, 1));
        drive_cycle(1'b1, 1'b1, pack_ops(1, 1, 1, 1));
        t = cyc;
        drain();
        checks++; if (pulse_cyc.size() != 1) begin errors++; $display("[TB] FAIL rstmid_count: got %0d pulses, expected 1", pulse_cyc.size()); end
        if (pulse_cyc.size() > 0) begin
            checks++; if (pulse_cyc[0] != t + C_LAT) begin errors++; $display("[TB] FAIL rstmid_latency: got cycle %0d, expected %0d", pulse_cyc[0], t + C_LAT); end
            checks++; if (pulse_res[0] !== pack_res(3, 3, 3, 3)) begin errors++; $display("[TB] FAIL rstmid_sum: got %h, expected %h", pulse_res[0], pack_res(3, 3, 3, 3)); end
            checks++; if (pulse_first[0] !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_first: got %b, expected 1", pulse_first[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_partial_discard();
        test_overflow();
        test_reset_mid_group();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipeline_acc_mc.md
Name: pipeline_acc_mc

Overview:
- Multi-channel, parametrised successor to the single-lane pipelined accumulator in the cnna compute path.
- C_CH lanes share one control stream. Each lane sums a runtime-programmable group of I_cnt_boundary consecutive accepted operands, which may arrive with gaps.
- Each lane emits one sign-extended sum per group at a fixed latency C_LAT.
- An early-ready strobe O_result_rdy_pre leads O_result_vld by C_PRE clocks so downstream buffers can pre-arm.

Parameters:
- C_CH, 4, number of parallel lanes
- C_CNT, 8, width of group-length counter / I_cnt_boundary
- C_IN1, 12, signed operand width per lane
- C_OUT, 20, signed result width per lane (C_OUT >= C_IN1)
- C_LAT, 6, clocks from last accepted operand to O_result_vld (C_LAT >= C_PRE+1)
- C_PRE, 4, lead of O_result_rdy_pre over O_result_vld (C_PRE >= 1)

Ports:
- I_clk  in  1  single clock
- I_rst  in  1  reset, synchronous, active-high
- I_cnt_boundary  in  C_CNT  operands per group; sampled while I_op_en=0, held stable while I_op_en=1
- I_op_en  in  1  layer enable; 0 clears counter and accumulators
- I_op_rdy  in  1  operand valid this clock (rdly=0)
- I_operand  in  C_CH*C_IN1  lane k at bits [k*C_IN1 +: C_IN1], two's complement
- O_result_first_flag  out  1  high with first O_result_vld after I_op_en rises
- O_result_rdy_pre  out  1  pulse C_PRE clocks before each O_result_vld
- O_result_vld  out  1  one-clock pulse, O_result valid
- O_result  out  C_CH*C_OUT  lane k at bits [k*C_OUT +: C_OUT]
- O_result_sat  out  C_CH  per-lane saturation flag, qualified by O_result_vld

Behaviour:
- Reset (I_rst=1): counter=0, accumulators=0, delay lines cleared. All outputs 0 on the next clock. Reset mid-group discards the partial group; no result is emitted for it.
- Boundary latch: eff_bnd = I_cnt_boundary, registered while I_op_en=0. A value of 0 is treated as 1.
- Accept: acc_en = I_op_en & I_op_rdy. When I_op_rdy=0, counter and accumulators hold; gaps are unlimited.
- Counter:
  - on acc_en, cnt <= (cnt == eff_bnd-1) ? 0 : cnt+1
  - last = acc_en & (cnt == eff_bnd-1)
- Lane accumulate, on acc_en: acc_k <= (cnt==0) ? sext(op_k) : acc_k + sext(op_k).
  - Arithmetic is C_OUT-bit two's complement and wraps on overflow (default build).
- Output timing, with last accepted at clock t:
  - sum is captured at t+1
  - O_result_rdy_pre=1 at exactly t+C_LAT-C_PRE
  - O_result_vld=1 and O_result=sum at exactly t+C_LAT
  - implement as a C_LAT-deep shift of (last, sums); no handshake or backpressure
- Between pulses, O_result holds its last value. O_result_sat and O_result_first_flag are 0 when O_result_vld=0.
- Back-to-back groups: with eff_bnd=1 and I_op_rdy always high, O_result_vld is high every clock. Successive groups never mix.
- First flag: an internal flag is set on the I_op_en rising edge and cleared after the first last. The flag travels with that group through the delay line.
- I_op_en falling:
  - counter and accumulators clear on the next clock; the partial group is discarded
  - groups already in the delay line still drain and emit normally
- Same-clock I_op_en=0 and I_op_rdy=1: the operand is ignored.

Optional Feature:
- Macro PIPELINE_ACC_MC_SAT_EN.
- Defined: each accumulate step saturates lane-wise. If the true sum exceeds 2^(C_OUT-1)-1 or falls below -2^(C_OUT-1), it clamps to that bound. The lane's sticky sat bit is set and travels with the group to O_result_sat. The sticky bit clears at the group's first operand.
- Undefined: arithmetic wraps; O_result_sat is tied to 0.

Test Plan:
- Reset check: I_rst=1 for 3 clocks, then release -> all outputs 0. Then bnd=3, lane0 ops 1,2,3 on consecutive clocks -> O_result_vld exactly 6 clocks after op 3 with lane0=6; O_result_rdy_pre 2 clocks after op 3; O_result_first_flag=1.
- bnd=1, C_CH=4, lane k op = k+10 for 8 clocks -> 8 consecutive O_result_vld with lane values 10,11,12,13; only the first has first_flag=1.
- bnd=4, ops 5,-3,7,-1 with I_op_rdy low for 2 clocks between each -> single result 8, timed 6 clocks after the 4th accept.
- bnd=5: after 3 ops drop I_op_en; re-raise with bnd=2, ops 4,4 -> no result for the partial group; exactly one result 8 with first_flag=1.
- Overflow, bnd=2, lane0 ops 2047,2047 with C_OUT=C_IN1=12 -> wrap build gives -2 with sat=0; PIPELINE_ACC_MC_SAT_EN build gives 2047 with O_result_sat[0]=1.
- Reset mid-group: I_rst pulse during the 2nd of 3 ops, then a full group 1,1,1 -> exactly one result 3.
